// File: rtl/axis_width_conv_pkg.sv
// Shared types and elaboration helpers for the AXI-Stream width converters.
package axis_width_conv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Ceiling log2, used to size lane counters at elaboration time.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Index of the highest lane that has at least one byte enable set; 0 when none.
    function automatic int last_kept_lane(input logic [63:0] keep, input int beats);
        int bytes_per_lane;
        int lane;
        bytes_per_lane = 64 / beats;
        lane           = 0;
        for (int b = 0; b < 64; b++) begin
            if (keep[b]) begin
                lane = b / bytes_per_lane;
            end
        end
        return lane;
    endfunction

endpackage

// File: rtl/axis_keep_last_lane.sv
// Priority encoder: wide TKEEP -> index of the highest narrow lane carrying data.
module axis_keep_last_lane
    import axis_width_conv_pkg::*;
#(
    parameter int KEEP_W = 64,
    parameter int BEATS  = 8,
    parameter int LANE_W = clog2(BEATS)
) (
    input  logic [KEEP_W-1:0] keep_i,
    output logic [LANE_W-1:0] lane_o
);

    // Highest kept lane of the incoming word.
    always_comb begin
        lane_o = LANE_W'(last_kept_lane(keep_i, BEATS));
    end

endmodule

// File: rtl/width_conv_512_64.sv
// AXI-Stream 512->64 width down-converter, lane 0 first, TKEEP-trimmed on the
// packet's final word, accepting the next wide word on the final narrow beat.
module width_conv_512_64
    import axis_width_conv_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 512,
    parameter int C_M00_AXIS_TDATA_WIDTH = 64,
    parameter int NUM_OF_BEATS           = C_S00_AXIS_TDATA_WIDTH / C_M00_AXIS_TDATA_WIDTH
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
    input  logic                                  S_AXIS_TVALID,
    input  logic                                  S_AXIS_TLAST,
    output logic                                  S_AXIS_TREADY,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
    output logic                                  M_AXIS_TVALID,
    output logic                                  M_AXIS_TLAST,
    input  logic                                  M_AXIS_TREADY
);

    localparam int S_W     = C_S00_AXIS_TDATA_WIDTH;
    localparam int M_W     = C_M00_AXIS_TDATA_WIDTH;
    localparam int S_KW    = S_W / 8;
    localparam int M_KW    = M_W / 8;
    localparam int LANE_W  = clog2(NUM_OF_BEATS);
    localparam logic [LANE_W-1:0] MAX_LANE = LANE_W'(NUM_OF_BEATS - 1);

    state_e              state_q, state_d;
    logic [LANE_W-1:0]   beat_q, beat_d;
    logic [LANE_W-1:0]   last_lane_q, last_lane_d;
    logic [S_W-1:0]      word_q;
    logic [S_KW-1:0]     keep_q;
    logic                tlast_q;

    logic [LANE_W-1:0]   kept_lane;
    logic                load;
    logic                final_beat;
    logic                s_ready;
    logic [M_W-1:0]      data_lanes [NUM_OF_BEATS];
    logic [M_KW-1:0]     keep_lanes [NUM_OF_BEATS];

    axis_keep_last_lane #(
        .KEEP_W (S_KW),
        .BEATS  (NUM_OF_BEATS),
        .LANE_W (LANE_W)
    ) u_last_lane (
        .keep_i (S_AXIS_TKEEP),
        .lane_o (kept_lane)
    );

    // Next state, lane counter and S-side acceptance; M_TREADY feeds S_TREADY combinationally.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        s_ready    = 1'b0;
        load       = 1'b0;
        final_beat = (beat_q == last_lane_q);
        case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                if (S_AXIS_TVALID) begin
                    load    = 1'b1;
                    state_d = SEND;
                    beat_d  = '0;
                end
            end
            SEND: begin
                if (M_AXIS_TREADY) begin
                    if (!final_beat) begin
                        beat_d = beat_q + 1'b1;
                    end else begin
                        s_ready = 1'b1;
                        if (S_AXIS_TVALID) begin
                            load   = 1'b1;
                            beat_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Only the packet's final word is trimmed; other words always run all lanes.
        last_lane_d = last_lane_q;
        if (load) begin
            last_lane_d = S_AXIS_TLAST ? kept_lane : MAX_LANE;
        end
    end

    // Control state: cleared asynchronously so a word in flight is dropped at once.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            last_lane_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            last_lane_q <= last_lane_d;
        end
    end

    // Wide holding registers; contents are only observed while in SEND.
    always_ff @(posedge aclk) begin
        if (load) begin
            word_q  <= S_AXIS_TDATA;
            keep_q  <= S_AXIS_TKEEP;
            tlast_q <= S_AXIS_TLAST;
        end
    end

    // Split the held word into narrow lanes for the beat mux.
    always_comb begin
        for (int l = 0; l < NUM_OF_BEATS; l++) begin
            data_lanes[l] = word_q[l*M_W +: M_W];
            keep_lanes[l] = keep_q[l*M_KW +: M_KW];
        end
    end

    // Outputs are forced to zero outside SEND, which also covers reset.
    always_comb begin
        M_AXIS_TVALID = (state_q == SEND);
        M_AXIS_TDATA  = '0;
        M_AXIS_TKEEP  = '0;
        M_AXIS_TLAST  = 1'b0;
        if (state_q == SEND) begin
            M_AXIS_TDATA = data_lanes[beat_q];
            M_AXIS_TKEEP = keep_lanes[beat_q];
            M_AXIS_TLAST = tlast_q && final_beat;
        end
        S_AXIS_TREADY = aresetn && s_ready;
    end

endmodule
